// File: rtl/gelato_types.sv
// Shared types for the gelato instruction-side refill path: refill FSM states and
// the default L1 I-cache line geometry.
package gelato_types;

  localparam int L1_ICACHE_LINE_WORDS = 8;
  localparam int L1_ICACHE_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    REFILL_IDLE,
    REFILL_FETCH,
    REFILL_RESP
  } refill_state_t;

  typedef logic [L1_ICACHE_LINE_WORDS*L1_ICACHE_WORD_WIDTH-1:0] icache_line_t;

endpackage

// File: rtl/gelato_sync_fifo.sv
// Single-clock FIFO with registered storage and a combinational head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module gelato_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] storage_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = storage_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) storage_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/gelato_icache_refill_server.sv
// L2-side server for I-cache line refills: queues line requests, reads each line word by
// word from memory and returns it in one beat. Optional perf counters: GELATO_REFILL_PERF_CNT_EN.
module gelato_icache_refill_server
  import gelato_types::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int LINE_WORDS     = 8,
  parameter int REQ_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rdy,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ADDR_WIDTH-1:0]            rsp_addr,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] rsp_data,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  input  logic                             mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]            mem_rsp_data
`ifdef GELATO_REFILL_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_lines_served,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  localparam int LINE_BITS  = LINE_WORDS * WORD_WIDTH;
  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam int OFF        = $clog2(LINE_BITS / 8);
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int CNT_W      = IDX_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

  refill_state_t         state_q, state_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      rcv_cnt_q, rcv_cnt_d;
  logic [LINE_BITS-1:0]  line_q, line_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_WIDTH-1:0] head_addr;

  assign req_ready = !fifo_full && rdy;
  assign fifo_push = req_valid && req_ready;

  gelato_sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (req_addr & LINE_MASK),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_addr)
  );

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    rcv_cnt_d     = rcv_cnt_q;
    line_d        = line_q;
    fifo_pop      = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = 1'b0;
    rsp_addr      = '0;
    rsp_data      = '0;
    mem_req_addr  = head_addr + (ADDR_WIDTH'(issue_cnt_q) * ADDR_WIDTH'(WORD_BYTES));

    case (state_q)
      REFILL_IDLE: begin
        if (!fifo_empty) state_d = REFILL_FETCH;
      end
      REFILL_FETCH: begin
        mem_req_valid = rdy && (issue_cnt_q < CNT_W'(LINE_WORDS));
        if (mem_req_valid && mem_req_ready) issue_cnt_d = issue_cnt_q + CNT_W'(1);
        // Capture ignores rdy: memory returns data regardless and cannot be stalled.
        if (mem_rsp_valid && (rcv_cnt_q < CNT_W'(LINE_WORDS))) begin
          line_d[rcv_cnt_q[IDX_W-1:0]*WORD_WIDTH +: WORD_WIDTH] = mem_rsp_data;
          rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
          if (rcv_cnt_q == CNT_W'(LINE_WORDS-1)) state_d = REFILL_RESP;
        end
      end
      REFILL_RESP: begin
        rsp_valid = 1'b1;
        rsp_addr  = head_addr;
        rsp_data  = line_q;
        if (rsp_ready && rdy) begin
          fifo_pop    = 1'b1;
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
          state_d     = REFILL_IDLE;
        end
      end
      default: state_d = REFILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REFILL_IDLE;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
    end
  end

  // Line data is only observable in RESP, after every word was rewritten.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

`ifdef GELATO_REFILL_PERF_CNT_EN
  logic [31:0] perf_lines_q, perf_lines_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_lines_d = perf_lines_q;
    perf_stall_d = perf_stall_q;
    if (rsp_valid && rsp_ready && rdy && (perf_lines_q != '1))
      perf_lines_d = perf_lines_q + 32'd1;
    if (((rsp_valid && !rsp_ready) || (mem_req_valid && !mem_req_ready)) &&
        (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lines_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_lines_q <= perf_lines_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_lines_served = perf_lines_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && mem_rsp_valid)
      assert (state_q == REFILL_FETCH && rcv_cnt_q < CNT_W'(LINE_WORDS))
        else $error("refill server: mem_rsp_valid with no outstanding read, word dropped");
  end
`endif

endmodule

// File: tb/tb_gelato_icache_refill_server.sv
// Directed bench for gelato_icache_refill_server with a latency-configurable memory model
// and scoreboards for issued memory addresses and returned lines.
module tb_gelato_icache_refill_server;
  import gelato_types::*;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [AW-1:0] req_addr = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr;
  icache_line_t rsp_data;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b1;
  logic [AW-1:0] mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [WW-1:0] mem_rsp_data = '0;
`ifdef GELATO_REFILL_PERF_CNT_EN
  logic [31:0]  perf_lines_served;
  logic [31:0]  perf_stall_cycles;
`endif

  gelato_icache_refill_server #(
    .ADDR_WIDTH     (AW),
    .WORD_WIDTH     (WW),
    .LINE_WORDS     (LW),
    .REQ_FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_addr      (rsp_addr),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
`ifdef GELATO_REFILL_PERF_CNT_EN
    ,
    .perf_lines_served (perf_lines_served),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  logic [AW-1:0] exp_line_q[$];
  logic [AW-1:0] exp_mem_q[$];
  pend_t         pend_q[$];
  int            cyc = 0;
  int            mem_lat = 1;
  int            reads_issued = 0;
  int            rsp_hs_cnt = 0;
  logic          mm_hs;
  logic [AW-1:0] mm_addr;
  logic [AW-1:0] mon_la;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic icache_line_t line_of(input logic [AW-1:0] la);
    icache_line_t l;
    for (int i = 0; i < LW; i++) l[i*WW +: WW] = la + 32'(i * 4);
    return l;
  endfunction

  task automatic expect_req(input logic [AW-1:0] a);
    logic [AW-1:0] la;
    la = a & ~32'h1F;
    exp_line_q.push_back(la);
    for (int i = 0; i < LW; i++) exp_mem_q.push_back(la + 32'(i * 4));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        expect_req(a);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("push_accepted", done, 1);
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 400) begin
      tick();
      k++;
    end
  endtask

  // Memory model: returns its own address as data, in order, mem_lat cycles after the read.
  always begin
    @(negedge clk);
    mm_hs   = mem_req_valid && mem_req_ready && !rst;
    mm_addr = mem_req_addr;
    if (mm_hs) begin
      reads_issued++;
      chk("mem_addr_expected", exp_mem_q.size() > 0, 1);
      if (exp_mem_q.size() > 0) chk("mem_addr", mm_addr, exp_mem_q.pop_front());
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      pend_q.delete();
      mem_rsp_valid = 1'b0;
    end else begin
      if (mm_hs) pend_q.push_back('{addr: mm_addr, due: cyc + mem_lat - 1});
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_q[0].addr;
        void'(pend_q.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // Response scoreboard: every accepted line is compared against the bench's expectation.
  always begin
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready && rdy) begin
      chk("rsp_expected", exp_line_q.size() > 0, 1);
      if (exp_line_q.size() > 0) begin
        mon_la = exp_line_q.pop_front();
        chk("rsp_addr", rsp_addr, mon_la);
        chk("rsp_data", rsp_data, line_of(mon_la));
      end
      rsp_hs_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r0;
    int hs0;
    int acc;
    bit done;
    logic [AW-1:0] addrs [5];
    logic [WW-1:0] w7;

    // Reset state
    repeat (3) tick();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    tick();

    // Single refill with 1-cycle memory, including minimum latency
    r0 = reads_issued;
    push_req(32'h0000_1234);
    wait_rsp(k);
    chk("t2_latency", k, LW + 2);
    chk("t2_rsp_addr", rsp_addr, 32'h0000_1220);
    w7 = rsp_data[7*WW +: WW];
    chk("t2_word7", w7, 32'h0000_123C);
    chk("t2_reads", reads_issued - r0, LW);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t2_rsp_valid_low", rsp_valid, 0);

    // Reset in the middle of a fetch
    push_req(32'h0000_4000);
    repeat (3) tick();
    chk("t1_fetching", mem_req_valid, 1);
    rst = 1'b1;
    #1;
    chk("t1_mem_req_valid", mem_req_valid, 0);
    chk("t1_rsp_valid", rsp_valid, 0);
    exp_line_q.delete();
    exp_mem_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("t1_req_ready", req_ready, 1);
    repeat (4) tick();
    chk("t1_idle_no_reads", mem_req_valid, 0);

    // Hold the response for 10 cycles
    push_req(32'h0000_8010);
    wait_rsp(k);
    chk("t4_rsp_seen", rsp_valid, 1);
    r0 = reads_issued;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_rsp_valid", rsp_valid, 1);
      chk("t4_rsp_addr", rsp_addr, 32'h0000_8000);
      chk("t4_rsp_data", rsp_data, line_of(32'h0000_8000));
      chk("t4_no_mem", mem_req_valid, 0);
    end
    chk("t4_no_reads", reads_issued - r0, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`ifdef GELATO_REFILL_PERF_CNT_EN
    chk("t6_lines_served", perf_lines_served, 1);
    chk("t6_stall_ge10", perf_stall_cycles >= 32'd10, 1);
`endif

    // FIFO fill: five back-to-back requests while responses are blocked
    for (int i = 0; i < 5; i++) addrs[i] = 32'h0001_001C + 32'(i * 32'h40);
    acc = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && acc < 4; i++) begin
      req_addr = addrs[acc];
      @(negedge clk);
      if (req_ready) begin
        expect_req(addrs[acc]);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    req_addr = addrs[4];
    chk("t3_accepted", acc, 4);
    chk("t3_full_ready", req_ready, 0);
    repeat (3) tick();
    chk("t3_still_full", req_ready, 0);
    hs0 = rsp_hs_cnt;
    rsp_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        chk("t3_fifth_after_hs", rsp_hs_cnt > hs0, 1);
        expect_req(addrs[4]);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("t3_fifth_accepted", done, 1);
    for (int i = 0; i < 500 && exp_line_q.size() > 0; i++) tick();
    chk("t3_drained", exp_line_q.size(), 0);
    chk("t3_hs_count", rsp_hs_cnt - hs0, 5);
    rsp_ready = 1'b0;
    tick();

    // Toggling mem ready, 3-cycle memory, rdy dropped mid-fetch; top-of-space line
    mem_lat = 3;
    r0 = reads_issued;
    push_req(32'hFFFF_FFE4);
    k = 0;
    while (!rsp_valid && k < 400) begin
      mem_req_ready = k[0];
      rdy = !(k >= 6 && k < 11);
      @(negedge clk);
      if (!rdy) chk("t5_frozen_issue", mem_req_valid, 0);
      @(posedge clk);
      #1;
      k++;
    end
    rdy = 1'b1;
    mem_req_ready = 1'b1;
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_rsp_addr", rsp_addr, 32'hFFFF_FFE0);
    chk("t5_reads", reads_issued - r0, LW);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (5) tick();
    chk("t5_reads_exact", reads_issued - r0, LW);
    chk("t5_mem_q_empty", exp_mem_q.size(), 0);
    chk("t5_line_q_empty", exp_line_q.size(), 0);
    mem_lat = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
